seg7_scan_mux: RTL

Downstream display stage for the digit counters. Takes several BCD digits and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables. Provides tear-free frame-synchronous updates, an inter-digit blanking gap against ghosting, and optional leading-zero suppression. Sits between the counter/digit logic and the uo_out/uio_out pins.

---
 rtl/seg7_pkg.sv | 44 ++++
 rtl/seg7_scan_mux_slot_timer.sv | 75 +++++++
 rtl/seg7_scan_mux.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 7-segment display path.
//   scan_state_t - SHOW/BLANK state of the digit scan FSM
//   SEG_0..SEG_9 - segment patterns {g,f,e,d,c,b,a}, 1 = lit
//   SEG_BLANK    - all segments off
//   seg7_decode  - BCD code to segment pattern; codes 10-15 give SEG_BLANK.
//                  It is also used by the single-digit decoder.
package seg7_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg7_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_mux_slot_timer.sv
// scan_slot_timer: slot counter, digit index and SHOW/BLANK FSM for the scan mux.
// Ports:
//   i_clk, i_reset - clock and synchronous active-high reset
//   o_state        - current FSM state (SHOW or BLANK)
//   o_index        - digit currently being scanned (0..NUM_DIGITS-1)
//   o_count        - slot counter (0..REFRESH_DIV-1)
//   o_wrap         - high in the cycle whose clock edge wraps the index to 0
//   o_frame_done   - registered pulse, high in exactly the o_wrap cycle
module scan_slot_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 2500,
  parameter int BLANK_CYCLES = 16,
  localparam int IDX_W = $clog2(NUM_DIGITS),
  localparam int CNT_W = $clog2(REFRESH_DIV)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output scan_state_t      o_state,
  output logic [IDX_W-1:0] o_index,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_PRE  = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  scan_state_t      r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_done;

  // frame_done is registered from the cycle before the wrap so that the pulse
  // lands on the wrap cycle itself; a load seen together with frame_done is
  // then the load that goes straight into the active register.
  logic w_pre_wrap;
  assign w_pre_wrap = (r_cnt == SLOT_PRE) && (r_idx == IDX_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_SHOW;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_pre_wrap;
      case (r_state)
        ST_SHOW: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == SHOW_LAST) r_state <= ST_BLANK;
        end
        default: begin
          if (r_cnt == SLOT_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_SHOW;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_index      = r_idx;
  assign o_count      = r_cnt;
  assign o_wrap       = (r_state == ST_BLANK) && (r_cnt == SLOT_LAST) && (r_idx == IDX_LAST);
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexes NUM_DIGITS BCD digits onto one 7-segment bus.
// Optional macro SEG7_SCAN_BRIGHTNESS_EN adds i_brightness[2:0] PWM dimming.
// Ports:
//   i_clk, i_reset   - clock and synchronous active-high reset
//   i_digits_bcd     - packed BCD, nibble i is digit i (digit 0 = LSD)
//   i_load           - captures i_digits_bcd / i_dp_mask into pending
//   i_dp_mask        - decimal point per digit
//   i_lz_blank_en    - leading-zero suppression enable
//   i_brightness     - (macro only) 7 = full on, 0 = 1/8 duty
//   o_segments       - {g,f,e,d,c,b,a}, 1 = lit
//   o_dp             - decimal point of the current digit
//   o_digit_en       - one-hot digit enable, zero during blanking
//   o_frame_done     - one-cycle pulse on the frame wrap cycle
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 2500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_digits_bcd,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic                    i_lz_blank_en,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
  input  logic [2:0]              i_brightness,
`endif
  output logic [6:0]              o_segments,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  scan_state_t      w_state;
  logic [IDX_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;
  logic             w_wrap;

  scan_slot_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .o_state      (w_state),
    .o_index      (w_idx),
    .o_count      (w_cnt),
    .o_wrap       (w_wrap),
    .o_frame_done (o_frame_done)
  );

  // Double-buffered digit data: loads land in pending, and pending moves to
  // active only on the frame wrap so a frame never mixes old and new digits.
  logic [4*NUM_DIGITS-1:0] r_pend_bcd, r_act_bcd;
  logic [NUM_DIGITS-1:0]   r_pend_dp,  r_act_dp;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_bcd <= '0;
      r_pend_dp  <= '0;
      r_act_bcd  <= '0;
      r_act_dp   <= '0;
    end else begin
      if (i_load) begin
        r_pend_bcd <= i_digits_bcd;
        r_pend_dp  <= i_dp_mask;
      end
      if (w_wrap) begin
        r_act_bcd <= i_load ? i_digits_bcd : r_pend_bcd;
        r_act_dp  <= i_load ? i_dp_mask    : r_pend_dp;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while every nibble seen
  // so far is zero. Digit 0 is never part of the walk.
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic                  w_zero_run;

  always_comb begin
    w_lz_blank = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run    = w_zero_run & (r_act_bcd[4*i +: 4] == 4'd0);
      w_lz_blank[i] = i_lz_blank_en & w_zero_run;
    end
  end

  logic [3:0]            w_nib;
  logic                  w_cur_dp;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_gate;

  assign w_nib    = r_act_bcd[{w_idx, 2'b00} +: 4];
  assign w_cur_dp = r_act_dp[w_idx];
  assign w_onehot = NUM_DIGITS'(1) << w_idx;

`ifdef SEG7_SCAN_BRIGHTNESS_EN
  logic [2:0] w_cnt_lo;
  assign w_cnt_lo = 3'(w_cnt);
  assign w_gate   = (w_cnt_lo <= i_brightness);
`else
  // The slot counter only feeds the brightness gate.
  logic w_unused_cnt;
  assign w_unused_cnt = ^w_cnt;
  assign w_gate       = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_segments <= SEG_BLANK;
      o_dp       <= 1'b0;
      o_digit_en <= '0;
    end else if (w_state == ST_SHOW) begin
      o_digit_en <= w_onehot & {NUM_DIGITS{w_gate}};
      o_segments <= w_lz_blank[w_idx] ? SEG_BLANK : seg7_decode(w_nib);
      o_dp       <= w_cur_dp;
    end else begin
      o_digit_en <= '0;
      o_segments <= SEG_BLANK;
      o_dp       <= 1'b0;
    end
  end

endmodule
